// File: rtl/uart_tx_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_slave_if
// Description : CPU data-memory bus bundle (ce/we/addr/sel/data) between a
//               bus master and the uart_tx_slave responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_slave_if;
    logic        ce;      // bus select for the responder
    logic        we;      // 1 = write, 0 = read
    logic [31:0] addr;    // byte address
    logic [3:0]  sel;     // byte enables
    logic [31:0] data_i;  // write data, master to responder
    logic [31:0] data_o;  // read data, responder to master

    modport master (
        output ce, we, addr, sel, data_i,
        input  data_o
    );

    modport slave (
        input  ce, we, addr, sel, data_i,
        output data_o
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_slave.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_slave
// Description : Memory-mapped 8N1 UART transmitter. The CPU pushes bytes into
//               a transmit FIFO through TXDATA; a per-bit baud counter and a
//               START/DATA/STOP frame machine serialise them onto tx. A level
//               interrupt reports an empty, idle transmitter.
//               Register map (addr[3:2]):
//                 0 TXDATA  : write pushes data_i[7:0], reads 0
//                 1 STATUS  : {count[3:0], ovf, empty, full, busy}; write 1
//                             to bit 3 clears ovf
//                 2 BAUDDIV : clock cycles per bit, 16 bits
//                 3 CTRL    : bit0 tx_en, bit1 int_en
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_slave #(
    parameter int          FIFO_DEPTH  = 8,       // power of two, 2..16
    parameter logic [15:0] DEFAULT_DIV = 16'd434  // BAUDDIV reset value
) (
    input  wire            clk,
    input  wire            rst,     // asynchronous, active low
    uart_tx_slave_if.slave bus,
    output logic           tx,
    output logic           tx_int
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int C_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    // One extra bit so a completely full FIFO is distinguishable from empty.
    localparam int C_CNT_W = C_PTR_W + 1;
    localparam logic [C_CNT_W-1:0] C_FULL_CNT = C_CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] C_REG_TXDATA = 2'd0;
    localparam logic [1:0] C_REG_STATUS = 2'd1;
    localparam logic [1:0] C_REG_BAUD   = 2'd2;
    localparam logic [1:0] C_REG_CTRL   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Registers and next-state values
    // ------------------------------------------------------------------------
    logic [7:0]         fifo_q [FIFO_DEPTH];
    logic [C_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [C_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [C_CNT_W-1:0] count_q,  count_d;
    logic               ovf_q,    ovf_d;
    logic [15:0]        baud_q,   baud_d;
    logic               tx_en_q,  tx_en_d;
    logic               int_en_q, int_en_d;

    state_t             state_q,  state_d;
    logic [15:0]        cnt_q,    cnt_d;     // cycles left in current bit
    logic [2:0]         bit_q,    bit_d;     // data bit index
    logic [7:0]         shift_q,  shift_d;   // byte being transmitted
    logic [15:0]        div_q,    div_d;     // divider latched for the frame
    logic               tx_q,     tx_d;
    logic               tx_int_q, tx_int_d;

    // ------------------------------------------------------------------------
    // Combinational wires
    // ------------------------------------------------------------------------
    logic        w_wr;
    logic        w_wr_txdata;
    logic        w_wr_status;
    logic        w_wr_baud;
    logic        w_wr_ctrl;
    logic        w_empty;
    logic        w_full;
    logic        w_busy;
    logic        w_pop;
    logic        w_push;
    logic        w_push_drop;
    logic        w_can_start;
    logic        w_bit_end;
    logic [15:0] w_div_eff;
    logic [7:0]  w_head;
    logic [3:0]  w_count4;
    logic [31:0] w_rdata;
    logic        w_unused;

    // ------------------------------------------------------------------------
    // Bus decode: every write is qualified by ce, we and sel[0]
    // ------------------------------------------------------------------------
    assign w_wr        = bus.ce & bus.we & bus.sel[0];
    assign w_wr_txdata = w_wr & (bus.addr[3:2] == C_REG_TXDATA);
    assign w_wr_status = w_wr & (bus.addr[3:2] == C_REG_STATUS);
    assign w_wr_baud   = w_wr & (bus.addr[3:2] == C_REG_BAUD);
    assign w_wr_ctrl   = w_wr & (bus.addr[3:2] == C_REG_CTRL);

    // Bits of the bus that the register map never looks at.
    assign w_unused = &{1'b0, bus.addr[31:4], bus.addr[1:0], bus.sel[3:1],
                        bus.data_i[31:16]};

    // ------------------------------------------------------------------------
    // FIFO status
    // ------------------------------------------------------------------------
    assign w_empty  = (count_q == '0);
    assign w_full   = (count_q == C_FULL_CNT);
    assign w_busy   = (state_q != ST_IDLE);
    assign w_head   = fifo_q[rd_ptr_q];
    assign w_count4 = 4'(count_q);

    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // only fails when nothing is leaving.
    assign w_push      = w_wr_txdata & (~w_full | w_pop);
    assign w_push_drop = w_wr_txdata & w_full & ~w_pop;

    // A zero divider would stall the bit counter; treat it as one.
    assign w_div_eff   = (baud_q == 16'd0) ? 16'd1 : baud_q;
    assign w_can_start = tx_en_q & ~w_empty;
    assign w_bit_end   = (cnt_q == 16'd0);

    // FIFO pointer and occupancy update
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + C_PTR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + C_PTR_W'(1);
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + C_CNT_W'(1);
            2'b01:   count_d = count_q - C_CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control/status register writes; an overflowing push wins over a clear
    always_comb begin
        baud_d   = baud_q;
        tx_en_d  = tx_en_q;
        int_en_d = int_en_q;
        ovf_d    = ovf_q;
        if (w_wr_baud) begin
            baud_d = bus.data_i[15:0];
        end
        if (w_wr_ctrl) begin
            tx_en_d  = bus.data_i[0];
            int_en_d = bus.data_i[1];
        end
        if (w_push_drop) begin
            ovf_d = 1'b1;
        end else if (w_wr_status && bus.data_i[3]) begin
            ovf_d = 1'b0;
        end
    end

    // Frame machine: next state, bit timing, serial data and pop request
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        div_d   = div_q;
        tx_d    = tx_q;
        w_pop   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (w_can_start) begin
                    w_pop   = 1'b1;
                    shift_d = w_head;
                    div_d   = w_div_eff;
                    cnt_d   = w_div_eff - 16'd1;
                    state_d = ST_START;
                    tx_d    = 1'b0;
                end
            end

            ST_START: begin
                if (w_bit_end) begin
                    cnt_d   = div_q - 16'd1;
                    bit_d   = 3'd0;
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end

            ST_DATA: begin
                if (w_bit_end) begin
                    cnt_d = div_q - 16'd1;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = shift_q[bit_q + 3'd1];
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end

            ST_STOP: begin
                if (w_bit_end) begin
                    // Chain straight into the next start bit when more data
                    // is waiting, so back-to-back frames have no idle gap.
                    if (w_can_start) begin
                        w_pop   = 1'b1;
                        shift_d = w_head;
                        div_d   = w_div_eff;
                        cnt_d   = w_div_eff - 16'd1;
                        state_d = ST_START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // Interrupt request: empty FIFO and idle transmitter, sampled one cycle late
    always_comb begin
        tx_int_d = int_en_q & w_empty & ~w_busy;
    end

    // Combinational read mux
    always_comb begin
        w_rdata = 32'd0;
        if (bus.ce && !bus.we) begin
            case (bus.addr[3:2])
                C_REG_STATUS: w_rdata = {24'd0, w_count4, ovf_q, w_empty, w_full, w_busy};
                C_REG_BAUD:   w_rdata = {16'd0, baud_q};
                C_REG_CTRL:   w_rdata = {30'd0, int_en_q, tx_en_q};
                default:      w_rdata = 32'd0;
            endcase
        end
    end

    assign bus.data_o = w_rdata;

    // FIFO storage; contents need no reset because the pointers are flushed
    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_q[wr_ptr_q] <= bus.data_i[7:0];
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            baud_q   <= DEFAULT_DIV;
            tx_en_q  <= 1'b0;
            int_en_q <= 1'b0;
            state_q  <= ST_IDLE;
            cnt_q    <= 16'd0;
            bit_q    <= 3'd0;
            shift_q  <= 8'd0;
            div_q    <= 16'd1;
            tx_q     <= 1'b1;
            tx_int_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            baud_q   <= baud_d;
            tx_en_q  <= tx_en_d;
            int_en_q <= int_en_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            div_q    <= div_d;
            tx_q     <= tx_d;
            tx_int_q <= tx_int_d;
        end
    end

    assign tx     = tx_q;
    assign tx_int = tx_int_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_slave
// Description : Self-checking bench for uart_tx_slave. A frame-level model
//               (byte queue plus frame start time/divider) predicts tx,
//               tx_int and read data every cycle; directed sections pin the
//               model with hand-computed values, then random bus traffic runs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_slave;

    localparam int          DEPTH   = 8;
    localparam logic [15:0] DEF_DIV = 16'd434;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tx;
    logic tx_int;

    uart_tx_slave_if bus ();

    uart_tx_slave #(
        .FIFO_DEPTH  (DEPTH),
        .DEFAULT_DIV (DEF_DIV)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .tx     (tx),
        .tx_int (tx_int)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Frame for byte 0x55: start, 1,0,1,0,1,0,1,0 (LSB first), stop
    bit exp55 [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model: byte queue and the frame currently on the line
    // ------------------------------------------------------------------------
    logic [7:0]  mq [$];
    logic [15:0] m_div    = DEF_DIV;
    bit          m_txen   = 1'b0;
    bit          m_inten  = 1'b0;
    bit          m_ovf    = 1'b0;
    bit          m_active = 1'b0;
    bit          m_txint  = 1'b0;
    int          cyc      = 0;
    int          m_s      = 0;
    int          m_fdiv   = 1;
    logic [7:0]  m_fbyte  = 8'd0;

    task automatic model_reset();
        mq.delete();
        m_div    = DEF_DIV;
        m_txen   = 1'b0;
        m_inten  = 1'b0;
        m_ovf    = 1'b0;
        m_active = 1'b0;
        m_txint  = 1'b0;
    endtask

    task automatic model_step();
        int          n_pre;
        bit          busy_pre;
        bit          fend;
        bit          pop;
        logic [15:0] div_pre;
        logic [7:0]  head;
        cyc++;
        n_pre    = mq.size();
        busy_pre = m_active;
        div_pre  = m_div;
        fend     = m_active && (cyc == m_s + 10 * m_fdiv);
        pop      = (!m_active || fend) && m_txen && (n_pre > 0);
        m_txint  = m_inten && (n_pre == 0) && !busy_pre;
        head     = 8'd0;
        if (pop) head = mq.pop_front();
        if (bus.ce && bus.we && bus.sel[0]) begin
            case (bus.addr[3:2])
                2'd0: begin
                    if (n_pre == DEPTH && !pop) m_ovf = 1'b1;
                    else mq.push_back(bus.data_i[7:0]);
                end
                2'd1: if (bus.data_i[3]) m_ovf = 1'b0;
                2'd2: m_div = bus.data_i[15:0];
                default: begin
                    m_txen  = bus.data_i[0];
                    m_inten = bus.data_i[1];
                end
            endcase
        end
        if (pop) begin
            m_active = 1'b1;
            m_s      = cyc;
            m_fdiv   = (div_pre == 16'd0) ? 1 : int'(div_pre);
            m_fbyte  = head;
        end else if (fend) begin
            m_active = 1'b0;
        end
    endtask

    function automatic logic exp_tx();
        int k;
        if (!m_active) return 1'b1;
        k = (cyc - m_s) / m_fdiv;
        if (k == 0) return 1'b0;
        if (k <= 8) return m_fbyte[k-1];
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_rd();
        int n;
        n = mq.size();
        if (!bus.ce || bus.we) return 32'd0;
        case (bus.addr[3:2])
            2'd1:    return {24'd0, 4'(n), m_ovf, (n == 0), (n == DEPTH), m_active};
            2'd2:    return {16'd0, m_div};
            2'd3:    return {30'd0, m_inten, m_txen};
            default: return 32'd0;
        endcase
    endfunction

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) model_reset();
        else model_step();
    end

    // Per-cycle comparison of every output against the model
    initial forever begin
        @(negedge clk);
        #1;
        check("cmp_tx",     32'(tx),     32'(exp_tx()));
        check("cmp_tx_int", 32'(tx_int), 32'(m_txint));
        check("cmp_data_o", bus.data_o,  exp_rd());
    end

    // ------------------------------------------------------------------------
    // Bus tasks: inputs change on the falling edge only
    // ------------------------------------------------------------------------
    task automatic wr(input logic [1:0] r, input logic [31:0] d, input logic [3:0] s = 4'hF);
        @(negedge clk);
        bus.ce     = 1'b1;
        bus.we     = 1'b1;
        bus.addr   = {28'd0, r, 2'b00};
        bus.sel    = s;
        bus.data_i = d;
        @(negedge clk);
        bus.ce     = 1'b0;
        bus.we     = 1'b0;
        bus.sel    = 4'h0;
    endtask

    task automatic rd_chk(input logic [1:0] r, input logic [31:0] exp, input string nm);
        @(negedge clk);
        bus.ce   = 1'b1;
        bus.we   = 1'b0;
        bus.addr = {28'd0, r, 2'b00};
        bus.sel  = 4'hF;
        #2;
        check(nm, bus.data_o, exp);
        bus.ce   = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        while (!done && n < 4000) begin
            @(negedge clk);
            bus.ce   = 1'b1;
            bus.we   = 1'b0;
            bus.addr = 32'h4;
            bus.sel  = 4'hF;
            #2;
            done = (bus.data_o[2:0] == 3'b100);
            n++;
        end
        bus.ce = 1'b0;
        check("wait_idle_bound", 32'(done), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        int          r;

        bus.ce = 1'b0; bus.we = 1'b0; bus.addr = 32'd0; bus.sel = 4'h0; bus.data_i = 32'd0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Reset state
        check("reset_tx",     32'(tx),     32'd1);
        check("reset_tx_int", 32'(tx_int), 32'd0);
        rd_chk(2'd1, 32'h04,  "reset_status");
        rd_chk(2'd2, 32'd434, "reset_bauddiv");
        rd_chk(2'd3, 32'd0,   "reset_ctrl");

        // Single 0x55 frame at 4 cycles per bit
        wr(2'd2, 32'd4);
        wr(2'd3, 32'd1);
        wr(2'd0, 32'h55);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            #2;
            check("frame55_bit", 32'(tx), 32'(exp55[(k-1)/4]));
        end
        rd_chk(2'd1, 32'h04, "frame55_idle");

        // Overflow: nine pushes into an eight-deep FIFO, then a burst
        wr(2'd3, 32'd0);
        for (int i = 0; i < 9; i++) wr(2'd0, 32'($urandom_range(0, 255)));
        rd_chk(2'd1, 32'h8A, "ovf_status");
        wr(2'd1, 32'h08);
        rd_chk(2'd1, 32'h82, "ovf_cleared");
        wr(2'd3, 32'd1);
        repeat (319) @(negedge clk);
        rd_chk(2'd1, 32'h05, "burst_last_stop");
        rd_chk(2'd1, 32'h04, "burst_done");

        // Full FIFO with push and pop on the same edge
        wr(2'd3, 32'd0);
        for (int i = 0; i < 8; i++) wr(2'd0, 32'($urandom_range(0, 255)));
        wr(2'd3, 32'd1);
        wr(2'd0, 32'($urandom_range(0, 255)));
        repeat (37) @(negedge clk);
        wr(2'd0, 32'($urandom_range(0, 255)));
        rd_chk(2'd1, 32'h83, "full_push_pop");
        wait_idle();

        // Interrupt behaviour at 2 cycles per bit
        wr(2'd2, 32'd2);
        wr(2'd3, 32'd3);
        repeat (2) @(negedge clk);
        #2;
        check("int_idle", 32'(tx_int), 32'd1);
        wr(2'd0, 32'hA5);
        #2;
        check("int_push_edge", 32'(tx_int), 32'd1);
        @(negedge clk);
        #2;
        check("int_dropped", 32'(tx_int), 32'd0);
        repeat (20) @(negedge clk);
        #2;
        check("int_busy_fall", 32'(tx_int), 32'd0);
        @(negedge clk);
        #2;
        check("int_rise", 32'(tx_int), 32'd1);

        // Writes without sel[0] are ignored
        wr(2'd0, 32'h3C, 4'b1110);
        rd_chk(2'd1, 32'h04, "sel_txdata_ignored");
        wr(2'd2, 32'h1234, 4'b1110);
        rd_chk(2'd2, 32'd2, "sel_baud_ignored");

        // Divider change during a frame only affects the next frame
        wr(2'd2, 32'd4);
        wr(2'd3, 32'd1);
        wr(2'd0, 32'h81);
        wr(2'd0, 32'h7E);
        wr(2'd2, 32'd8);
        repeat (115) @(negedge clk);
        rd_chk(2'd1, 32'h05, "baud_change_tail");
        rd_chk(2'd1, 32'h04, "baud_change_done");

        // Random bus traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            r = $urandom_range(0, 99);
            a = $urandom;
            d = $urandom;
            bus.ce     = 1'b0;
            bus.we     = 1'b0;
            bus.sel    = ($urandom_range(0, 9) == 0) ? 4'b1110 : 4'hF;
            bus.data_i = d;
            if (r < 18) begin
                bus.ce = 1'b1; bus.we = 1'b1; bus.addr = {a[31:4], 2'd0, a[1:0]};
            end else if (r < 22) begin
                bus.ce = 1'b1; bus.we = 1'b1; bus.addr = {a[31:4], 2'd3, a[1:0]};
                bus.data_i = {30'd0, d[1], (d[3:2] != 2'b00)};
            end else if (r < 25) begin
                bus.ce = 1'b1; bus.we = 1'b1; bus.addr = {a[31:4], 2'd2, a[1:0]};
                bus.data_i = 32'($urandom_range(0, 3));
            end else if (r < 28) begin
                bus.ce = 1'b1; bus.we = 1'b1; bus.addr = {a[31:4], 2'd1, a[1:0]};
            end else if (r < 60) begin
                bus.ce = 1'b1; bus.we = 1'b0; bus.addr = a;
            end else begin
                bus.we = d[31]; bus.addr = a;
            end
        end
        bus.ce = 1'b0;
        bus.we = 1'b0;
        wr(2'd3, 32'd1);
        wait_idle();

        // Asynchronous reset in the middle of a frame flushes the FIFO
        wr(2'd2, 32'd4);
        wr(2'd3, 32'd1);
        wr(2'd0, 32'h00);
        wr(2'd0, 32'hFF);
        #2;
        check("pre_reset_start_bit", 32'(tx), 32'd0);
        #1;
        rst = 1'b0;
        #1;
        check("async_reset_tx",     32'(tx),     32'd1);
        check("async_reset_tx_int", 32'(tx_int), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        rd_chk(2'd1, 32'h04,  "post_reset_status");
        rd_chk(2'd2, 32'd434, "post_reset_bauddiv");
        rd_chk(2'd3, 32'd0,   "post_reset_ctrl");
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
